// File: rtl/rr_mux_sched.sv
// Round-robin 4:1 mux scheduler with HOLD-cycle grant quantum; optional hand_cnt via RR_MUX_SCHED_STATS_EN.
// Latency: req -> gnt/sel one edge; gnt -> y/y_valid one further edge.
// Backpressure: none; requesters wait on req until granted, a quantum ends only when others wait.
module rr_mux_sched #(
    parameter int DW   = 2,
    parameter int HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] data,
    output logic [3:0]      gnt,
    output logic [1:0]      sel,
    output logic [DW-1:0]   y,
    output logic            y_valid,
    output logic            busy
`ifdef RR_MUX_SCHED_STATS_EN
    ,
    output logic [7:0]      hand_cnt
`endif
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HCNT_LAST = 8'(HOLD - 1);

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [1:0] sel_n;
    logic [7:0] hcnt, hcnt_n;
    logic [3:0] gnt_n;
    logic [3:0] pend;
    logic       rel;

    // First set bit of m, scanning circularly from p.
    function automatic logic [1:0] win(input logic [1:0] p, input logic [3:0] m);
        logic [1:0] r;
        logic [1:0] idx;
        logic       found;
        r     = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && m[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign busy = |gnt;
    assign pend = req & ~gnt;
    assign rel  = !req[sel] || ((hcnt == HCNT_LAST) && (pend != 4'b0000));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            hcnt  <= 8'd0;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            hcnt  <= hcnt_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hcnt_n  = hcnt;
        gnt_n   = gnt;
        sel_n   = sel;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_n = GRANT;
                    sel_n   = win(ptr, req);
                    gnt_n   = 4'b0001 << sel_n;
                    hcnt_n  = 8'd0;
                end
            end
            GRANT: begin
                if (!rel) begin
                    // Uncontended at quantum end: renew rather than drop.
                    hcnt_n = (hcnt == HCNT_LAST) ? 8'd0 : hcnt + 8'd1;
                end else begin
                    ptr_n  = sel + 2'd1;
                    hcnt_n = 8'd0;
                    if (pend != 4'b0000) begin
                        sel_n = win(sel + 2'd1, pend);
                        gnt_n = 4'b0001 << sel_n;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 4'b0000;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= busy;
            if (busy) begin
                y <= data[DW*sel +: DW];
            end
        end
    end

`ifdef RR_MUX_SCHED_STATS_EN
    logic handover;
    assign handover = (state == GRANT) && rel && (pend != 4'b0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            hand_cnt <= 8'd0;
        end else if (handover && (hand_cnt != 8'hFF)) begin
            hand_cnt <= hand_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux_sched.sv
// Randomized and directed bench for rr_mux_sched against an owner/quantum reference model.
module tb_rr_mux_sched;

    localparam int DW   = 2;
    localparam int HOLD = 4;

    logic            clk;
    logic            rst;
    logic [3:0]      req;
    logic [4*DW-1:0] data;
    logic [3:0]      gnt;
    logic [1:0]      sel;
    logic [DW-1:0]   y;
    logic            y_valid;
    logic            busy;
`ifdef RR_MUX_SCHED_STATS_EN
    logic [7:0]      hand_cnt;
`endif

    rr_mux_sched #(.DW(DW), .HOLD(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data    (data),
        .gnt     (gnt),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid),
        .busy    (busy)
`ifdef RR_MUX_SCHED_STATS_EN
        ,
        .hand_cnt(hand_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 = nobody), cycles held in current quantum.
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_held  = 0;
    int            m_sel   = 0;
    int            m_hand  = 0;
    logic [DW-1:0] m_y     = '0;
    logic          m_yv    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input int start, input logic [3:0] mask);
        for (int k = 0; k < 4; k++) begin
            if (mask[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge();
        logic [3:0] others;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 0;
            m_y = '0; m_yv = 1'b0; m_hand = 0;
            return;
        end
        m_yv = (m_owner >= 0);
        if (m_owner >= 0) m_y = data[m_sel*DW +: DW];
        if (m_owner < 0) begin
            if (req != 4'b0000) begin
                m_owner = pick(m_ptr, req);
                m_sel   = m_owner;
                m_held  = 1;
            end
        end else begin
            others = req;
            others[m_owner] = 1'b0;
            if (!req[m_owner] || (m_held == HOLD && others != 4'b0000)) begin
                m_ptr = (m_owner + 1) % 4;
                if (others != 4'b0000) begin
                    m_owner = pick(m_ptr, others);
                    m_sel   = m_owner;
                    m_held  = 1;
                    if (m_hand < 255) m_hand++;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_held = (m_held == HOLD) ? 1 : m_held + 1;
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] eg;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check("gnt",     32'(gnt),     32'(eg));
        check("sel",     32'(sel),     32'(m_sel));
        check("busy",    32'(busy),    32'(m_owner >= 0));
        check("y_valid", 32'(y_valid), 32'(m_yv));
        check("y",       32'(y),       32'(m_y));
`ifdef RR_MUX_SCHED_STATS_EN
        check("hand_cnt", 32'(hand_cnt), 32'(m_hand));
`endif
    endtask

    task automatic step(input logic r, input logic [3:0] q, input logic [4*DW-1:0] d);
        rst  = r;
        req  = q;
        data = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    int t3_hits;

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        data = '0;
        @(negedge clk);

        // Reset state
        step(1'b1, 4'b0000, 8'h00);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_yv",  32'(y_valid), 32'h0);

        // Single request from requester 1
        step(1'b0, 4'b0010, 8'b0000_1100);
        check("t1_gnt", 32'(gnt), 32'h2);
        check("t1_sel", 32'(sel), 32'h1);
        check("t1_yv0", 32'(y_valid), 32'h0);
        step(1'b0, 4'b0010, 8'b0000_1100);
        check("t1_y",   32'(y), 32'h3);
        check("t1_yv1", 32'(y_valid), 32'h1);
        step(1'b0, 4'b0000, 8'h00);
        check("t1_drop_gnt", 32'(gnt), 32'h0);
        check("t1_drop_yv",  32'(y_valid), 32'h1);
        step(1'b0, 4'b0000, 8'h00);
        check("t1_drop_yv2", 32'(y_valid), 32'h0);

        // All four contending from reset: 4-cycle quanta, order 0,1,2,3,0
        step(1'b1, 4'b0000, 8'h00);
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 4'b1111, 8'($urandom));
            check("t2_seq", 32'(gnt), 32'(4'b0001 << ((i / HOLD) % 4)));
        end

        // Uncontended grant renews its quantum indefinitely
        step(1'b1, 4'b0000, 8'h00);
        t3_hits = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'b0100, 8'($urandom));
            if (gnt == 4'b0100) t3_hits++;
        end
        check("t3_hold", 32'(t3_hits), 32'd20);

        // Early release and re-raise while another is granted
        step(1'b1, 4'b0000, 8'h00);
        step(1'b0, 4'b0011, 8'h1B);
        check("t4_first", 32'(gnt), 32'h1);
        step(1'b0, 4'b0011, 8'h1B);
        step(1'b0, 4'b0010, 8'h1B);
        check("t4_early", 32'(gnt), 32'h2);
        for (int i = 0; i < 6; i++) step(1'b0, 4'b0011, 8'($urandom));

        // Reset mid-grant
        step(1'b1, 4'b0000, 8'h00);
        step(1'b0, 4'b1000, 8'hC0);
        step(1'b0, 4'b1000, 8'hC0);
        step(1'b1, 4'b1000, 8'hC0);
        check("t5_gnt",  32'(gnt), 32'h0);
        check("t5_y",    32'(y), 32'h0);
        check("t5_yv",   32'(y_valid), 32'h0);
        step(1'b0, 4'b1000, 8'hC0);
        check("t5_regnt", 32'(gnt), 32'h8);

`ifdef RR_MUX_SCHED_STATS_EN
        // Handover counter saturation and clear
        step(1'b1, 4'b0000, 8'h00);
        for (int i = 0; i < 1100; i++) step(1'b0, 4'b1111, 8'($urandom));
        check("t6_sat", 32'(hand_cnt), 32'd255);
        step(1'b1, 4'b1111, 8'h00);
        check("t6_clr", 32'(hand_cnt), 32'd0);
`endif

        // Randomized traffic with occasional resets
        step(1'b1, 4'b0000, 8'h00);
        begin
            logic [3:0] rq;
            rq = 4'b0000;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
                step(($urandom_range(0, 199) == 0), rq, 8'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
